// File: rtl/ballot_controller.sv
// ballot_controller -- presiding-officer ballot sequencer.
// Arms one ballot at a time, admits exactly one vote per ballot (lowest
// candidate index wins on simultaneous presses), blocks and counts presses
// made with no ballot armed, and holds the vote-accepted indication for
// HOLD_CYCLES cycles after each accepted vote.
// Optional feature: define BALLOT_TIMEOUT_EN to expire an armed ballot after
// TIMEOUT_CYCLES cycles with no press. Without it, the timeout output is tied
// low and no timeout counter exists.
module ballot_controller #(
  parameter int NUM_CAND       = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_issue,
  input  logic [NUM_CAND-1:0] cand_valid,
  output logic [NUM_CAND-1:0] vote_strobe,
  output logic                ready,
  output logic                busy,
  output logic                blocked_press,
  output logic [7:0]          blocked_count,
  output logic [15:0]         total_votes,
  output logic                timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [NUM_CAND-1:0] sel_onehot;
  logic                press;
  logic                voting;
  logic                blocked_evt;

  // Lowest-index set bit of the presses: x & -x isolates the lowest one.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    sel_onehot = '0;
    sel_onehot = cand_valid & (~cand_valid + NUM_CAND'(1));
  end

  assign press  = |cand_valid;
  assign voting = ~mode;
  // A press is rejected whenever no ballot is armed, but only in voting mode;
  // in result-display mode presses are browsing and are ignored entirely.
  assign blocked_evt = voting & press & (state != ARMED);

`ifdef BALLOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign timeout = 1'b0;
`endif

  // Ballot state machine with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: async reset clears every state bit and counter; there is no
    // storage here that may be left unreset.
    if (!reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      vote_strobe   <= '0;
      ready         <= 1'b0;
      busy          <= 1'b0;
      blocked_press <= 1'b0;
      blocked_count <= '0;
      total_votes   <= '0;
`ifdef BALLOT_TIMEOUT_EN
      to_cnt        <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse outputs default
      // low here and a later assignment in the same block overrides them.
      vote_strobe   <= '0;
      blocked_press <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      timeout       <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (voting && ballot_issue) begin
            state <= ARMED;
            ready <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end

        ARMED: begin
          if (!voting) begin
            // Switching to result display withdraws the ballot.
            state <= IDLE;
            ready <= 1'b0;
          end else if (press) begin
            // A press wins over an expiry on the same edge.
            vote_strobe <= sel_onehot;
            if (total_votes != 16'hFFFF) total_votes <= total_votes + 16'd1;
            state    <= HOLD;
            ready    <= 1'b0;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
`ifdef BALLOT_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state   <= IDLE;
            ready   <= 1'b0;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        HOLD: begin
          // Mode changes and ballot requests do not shorten or extend HOLD.
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      // Rejected presses: pulse plus saturating count.
      if (blocked_evt) begin
        blocked_press <= 1'b1;
        if (blocked_count != 8'hFF) blocked_count <= blocked_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller. Expected vote strobes are pushed
// to a scoreboard queue when a press is driven and popped when the DUT
// responds. Build with BALLOT_TIMEOUT_EN defined to exercise the timeout.
module tb_ballot_controller;

  localparam int NC   = 4;
  localparam int HOLD = 10;
`ifdef BALLOT_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1000;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mode = 1'b0;
  logic          ballot_issue = 1'b0;
  logic [NC-1:0] cand_valid = '0;
  logic [NC-1:0] vote_strobe;
  logic          ready;
  logic          busy;
  logic          blocked_press;
  logic [7:0]    blocked_count;
  logic [15:0]   total_votes;
  logic          timeout;

  ballot_controller #(
    .NUM_CAND(NC),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .ballot_issue(ballot_issue),
    .cand_valid(cand_valid),
    .vote_strobe(vote_strobe),
    .ready(ready),
    .busy(busy),
    .blocked_press(blocked_press),
    .blocked_count(blocked_count),
    .total_votes(total_votes),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int exp_total = 0;
  int exp_blocked = 0;
  int exp_strobes = 0;
  logic [NC-1:0] exp_q[$];

  // Monitor: counts output pulses at the falling edge, away from the active edge.
  int cycle = 0;
  int strobe_pulses = 0;
  int blk_pulses = 0;
  int to_pulses = 0;
  int strobe_cycles[$];
  always @(negedge clock) begin
    cycle++;
    if (vote_strobe != '0) begin
      strobe_pulses++;
      strobe_cycles.push_back(cycle);
    end
    if (blocked_press) blk_pulses++;
    if (timeout) to_pulses++;
  end

  function automatic logic [NC-1:0] lowest(input logic [NC-1:0] p);
    logic [NC-1:0] r;
    r = '0;
    for (int i = NC - 1; i >= 0; i--) if (p[i]) r = '0 | (NC'(1) << i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic arm();
    ballot_issue = 1'b1;
    tick();
    ballot_issue = 1'b0;
  endtask

  // Drives an accepted press and records the expected strobe and count.
  task automatic press_vote(input logic [NC-1:0] pat);
    exp_q.push_back(lowest(pat));
    exp_strobes++;
    if (exp_total < 65535) exp_total++;
    cand_valid = pat;
    tick();
    cand_valid = '0;
  endtask

  task automatic blocked_pulse(input logic [NC-1:0] pat);
    cand_valid = pat;
    tick();
    cand_valid = '0;
    if (exp_blocked < 255) exp_blocked++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || ready !== 1'b0) && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL wait_idle: busy=%b ready=%b still active after %0d cycles", busy, ready, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({vote_strobe, ready, busy, blocked_press, timeout} !== '0 || blocked_count !== 8'd0 ||
        total_votes !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: strobe=%b ready=%b busy=%b blk=%b to=%b bcnt=%0d tot=%0d, want all 0",
               vote_strobe, ready, busy, blocked_press, timeout, blocked_count, total_votes);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_vote();
    logic [NC-1:0] e;
    int n;
    arm();
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", ready); end
    tick();
    press_vote(4'b0100);
    e = exp_q.pop_front();
    tests++;
    if (vote_strobe !== e) begin fails++; $display("FAIL single_strobe: got %b want %b", vote_strobe, e); end
    tests++;
    if (total_votes !== 16'(exp_total)) begin fails++; $display("FAIL single_total: got %0d want %0d", total_votes, exp_total); end
    tests++;
    if (busy !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL single_hold_entry: busy=%b ready=%b want 1/0", busy, ready); end
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      tick();
      if (busy === 1'b1) n++;
    end
    tests++;
    if (n != HOLD) begin fails++; $display("FAIL single_busy_len: got %0d want %0d", n, HOLD); end
    tests++;
    if (strobe_pulses != exp_strobes) begin fails++; $display("FAIL single_strobe_count: got %0d want %0d", strobe_pulses, exp_strobes); end
  endtask

  task automatic test_priority();
    logic [NC-1:0] pats[4] = '{4'b1010, 4'b1100, 4'b0111, 4'b1000};
    logic [NC-1:0] e;
    foreach (pats[i]) begin
      arm();
      press_vote(pats[i]);
      e = exp_q.pop_front();
      tests++;
      if (vote_strobe !== e) begin fails++; $display("FAIL prio_strobe[%0d]: got %b want %b", i, vote_strobe, e); end
      tests++;
      if (total_votes !== 16'(exp_total) || blocked_count !== 8'(exp_blocked)) begin
        fails++;
        $display("FAIL prio_counts[%0d]: tot=%0d bcnt=%0d want %0d/%0d", i, total_votes, blocked_count, exp_total, exp_blocked);
      end
      wait_idle();
    end
  endtask

  task automatic test_blocked();
    logic [NC-1:0] pats[3] = '{4'b0001, 4'b1000, 4'b0110};
    logic [NC-1:0] e;
    int b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_total = 0;
    exp_blocked = 0;
    b0 = blk_pulses;
    foreach (pats[i]) begin
      blocked_pulse(pats[i]);
      tests++;
      if (blocked_press !== 1'b1) begin fails++; $display("FAIL blk_idle_pulse[%0d]: got %b want 1", i, blocked_press); end
      tick();
    end
    arm();
    press_vote(4'b0001);
    e = exp_q.pop_front();
    tests++;
    if (vote_strobe !== e) begin fails++; $display("FAIL blk_vote_strobe: got %b want %b", vote_strobe, e); end
    repeat (3) tick();
    blocked_pulse(4'b0100);
    tests++;
    if (blocked_press !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL blk_hold_pulse: blk=%b busy=%b want 1/1", blocked_press, busy); end
    wait_idle();
    tick();
    tests++;
    if (blocked_count !== 8'd4) begin fails++; $display("FAIL blk_count: got %0d want 4", blocked_count); end
    tests++;
    if (blk_pulses - b0 != 4) begin fails++; $display("FAIL blk_pulses: got %0d want 4", blk_pulses - b0); end
    tests++;
    if (total_votes !== 16'd1 || strobe_pulses != exp_strobes) begin
      fails++;
      $display("FAIL blk_no_extra_vote: tot=%0d strobes=%0d want 1/%0d", total_votes, strobe_pulses, exp_strobes);
    end
  endtask

  task automatic test_mode_abort();
    int b0;
    arm();
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready_armed: got %b want 1", ready); end
    b0 = blk_pulses;
    mode = 1'b1;
    tick();
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL abort_ready_drop: got %b want 0", ready); end
    cand_valid = 4'b0001; tick(); cand_valid = '0; tick();
    cand_valid = 4'b0110; tick(); cand_valid = '0;
    ballot_issue = 1'b1; tick(); ballot_issue = 1'b0; tick();
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL abort_issue_ignored: ready=%b want 0", ready); end
    tests++;
    if (blocked_count !== 8'(exp_blocked) || blk_pulses != b0 || strobe_pulses != exp_strobes) begin
      fails++;
      $display("FAIL abort_display_presses: bcnt=%0d blkp=%0d strobes=%0d want %0d/%0d/%0d",
               blocked_count, blk_pulses, strobe_pulses, exp_blocked, b0, exp_strobes);
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_same_edge();
    logic [NC-1:0] e;
    ballot_issue = 1'b1;
    cand_valid = 4'b0001;
    tick();
    ballot_issue = 1'b0;
    cand_valid = '0;
    exp_blocked++;
    tests++;
    if (ready !== 1'b1 || blocked_press !== 1'b1 || blocked_count !== 8'(exp_blocked)) begin
      fails++;
      $display("FAIL same_arm_edge: ready=%b blk=%b bcnt=%0d want 1/1/%0d", ready, blocked_press, blocked_count, exp_blocked);
    end
    press_vote(4'b0100);
    e = exp_q.pop_front();
    tests++;
    if (vote_strobe !== e) begin fails++; $display("FAIL same_vote_strobe: got %b want %b", vote_strobe, e); end
    repeat (HOLD - 1) tick();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL same_last_busy: got %b want 1", busy); end
    blocked_pulse(4'b0010);
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || blocked_press !== 1'b1 || blocked_count !== 8'(exp_blocked)) begin
      fails++;
      $display("FAIL same_last_hold_edge: busy=%b ready=%b blk=%b bcnt=%0d want 0/0/1/%0d",
               busy, ready, blocked_press, blocked_count, exp_blocked);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NC-1:0] pats[3] = '{4'b1100, 4'b1111, 4'b1000};
    logic [NC-1:0] e;
    int idx;
    int n;
    idx = strobe_cycles.size();
    ballot_issue = 1'b1;
    foreach (pats[i]) begin
      n = 0;
      while (ready !== 1'b1 && n < 50) begin tick(); n++; end
      tests++;
      if (n >= 50) begin fails++; $display("FAIL b2b_wait_ready[%0d]: ready never rose", i); end
      press_vote(pats[i]);
      e = exp_q.pop_front();
      tests++;
      if (vote_strobe !== e) begin fails++; $display("FAIL b2b_strobe[%0d]: got %b want %b", i, vote_strobe, e); end
    end
    ballot_issue = 1'b0;
    wait_idle();
    tick();
    tests++;
    if (strobe_cycles.size() != idx + 3) begin
      fails++;
      $display("FAIL b2b_strobe_count: got %0d want 3", strobe_cycles.size() - idx);
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (strobe_cycles[idx+i+1] - strobe_cycles[idx+i] != HOLD + 2) begin
          fails++;
          $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, strobe_cycles[idx+i+1] - strobe_cycles[idx+i], HOLD + 2);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int b0;
    b0 = blk_pulses;
    cand_valid = 4'b0001;
    repeat (260) tick();
    cand_valid = '0;
    exp_blocked = (exp_blocked + 260 > 255) ? 255 : exp_blocked + 260;
    tick();
    tests++;
    if (blocked_count !== 8'(exp_blocked)) begin fails++; $display("FAIL sat_blocked_count: got %0d want %0d", blocked_count, exp_blocked); end
    tests++;
    if (blk_pulses - b0 != 260) begin fails++; $display("FAIL sat_blocked_pulses: got %0d want 260", blk_pulses - b0); end
  endtask

`ifdef BALLOT_TIMEOUT_EN
  task automatic test_timeout();
    logic [NC-1:0] e;
    int n;
    int s0;
    arm();
    n = 1;
    while (ready === 1'b1 && n < 200) begin
      tick();
      if (ready === 1'b1) n++;
    end
    tests++;
    if (n != TO) begin fails++; $display("FAIL to_armed_len: got %0d want %0d", n, TO); end
    tests++;
    if (timeout !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b want 1", timeout); end
    tick();
    tests++;
    if (timeout !== 1'b0) begin fails++; $display("FAIL to_pulse_len: got %b want 0", timeout); end
    s0 = strobe_pulses;
    blocked_pulse(4'b0001);
    tests++;
    if (blocked_press !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL to_press_after: blk=%b ready=%b want 1/0", blocked_press, ready); end
    tick();
    tests++;
    if (strobe_pulses != s0) begin fails++; $display("FAIL to_no_vote: strobes=%0d want %0d", strobe_pulses, s0); end
    arm();
    repeat (TO - 1) tick();
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL to_before_expiry: ready=%b want 1", ready); end
    press_vote(4'b0010);
    e = exp_q.pop_front();
    tests++;
    if (vote_strobe !== e || timeout !== 1'b0) begin
      fails++;
      $display("FAIL to_press_wins: strobe=%b to=%b want %b/0", vote_strobe, timeout, e);
    end
    wait_idle();
    tests++;
    if (to_pulses != 1) begin fails++; $display("FAIL to_pulse_total: got %0d want 1", to_pulses); end
  endtask
`else
  task automatic test_timeout();
    logic [NC-1:0] e;
    arm();
    repeat (TO + 100) tick();
    tests++;
    if (ready !== 1'b1 || to_pulses != 0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL persist_armed: ready=%b to_pulses=%0d to=%b want 1/0/0", ready, to_pulses, timeout);
    end
    press_vote(4'b0001);
    e = exp_q.pop_front();
    tests++;
    if (vote_strobe !== e) begin fails++; $display("FAIL persist_vote: got %b want %b", vote_strobe, e); end
    wait_idle();
  endtask
`endif

  task automatic test_reset_mid_hold();
    logic [NC-1:0] e;
    int s0;
    arm();
    press_vote(4'b1000);
    e = exp_q.pop_front();
    tests++;
    if (vote_strobe !== e) begin fails++; $display("FAIL rst_vote_strobe: got %b want %b", vote_strobe, e); end
    repeat (4) tick();
    tests++;
    if (busy !== 1'b1 || blocked_count === 8'd0 || total_votes === 16'd0) begin
      fails++;
      $display("FAIL rst_pre_state: busy=%b bcnt=%0d tot=%0d want busy 1, counts nonzero", busy, blocked_count, total_votes);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || total_votes !== 16'd0 || blocked_count !== 8'd0 || vote_strobe !== '0) begin
      fails++;
      $display("FAIL rst_async_clear: busy=%b ready=%b tot=%0d bcnt=%0d strobe=%b want all 0",
               busy, ready, total_votes, blocked_count, vote_strobe);
    end
    exp_total = 0;
    exp_blocked = 0;
    tick();
    reset = 1'b1;
    tick();
    s0 = strobe_pulses;
    blocked_pulse(4'b0001);
    tests++;
    if (blocked_press !== 1'b1 || blocked_count !== 8'(exp_blocked) || busy !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle_after: blk=%b bcnt=%0d busy=%b ready=%b want 1/%0d/0/0",
               blocked_press, blocked_count, busy, ready, exp_blocked);
    end
    tick();
    tests++;
    if (strobe_pulses != s0) begin fails++; $display("FAIL rst_no_vote: strobes=%0d want %0d", strobe_pulses, s0); end
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_priority();
    test_blocked();
    test_mode_abort();
    test_same_edge();
    test_back_to_back();
    test_saturation();
    test_timeout();
    test_reset_mid_hold();
    tests++;
    if (strobe_pulses != exp_strobes || exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_strobes: got %0d strobes, %0d pending, want %0d/0", strobe_pulses, exp_q.size(), exp_strobes);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
- Presiding-officer ballot sequencer that sits between the per-candidate debounced valid-vote pulses and the vote logger.
- Admits exactly one vote per issued ballot, arbitrating between candidates with fixed priority.
- Blocks and counts presses made with no ballot armed.
- Drives the vote-accepted indication for the duration of a fixed hold window.

Parameters:
- NUM_CAND, 4, number of candidate inputs (2..8).
- HOLD_CYCLES, 10, cycles spent in HOLD after an accepted vote (>=1).
- TIMEOUT_CYCLES, 1000, ARMED-state timeout in cycles; used only with BALLOT_TIMEOUT_EN (>=2).

Ports:
- clock, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous active-low reset; asserts immediately, releases synchronously to clock.
- mode, input, 1, 0 = voting, 1 = result display.
- ballot_issue, input, 1, officer request to arm one ballot; level-sampled.
- cand_valid, input, NUM_CAND, debounced single-cycle valid-vote pulses; bit i = candidate i+1.
- vote_strobe, output, NUM_CAND, registered one-hot, one-cycle increment command to the logger.
- ready, output, 1, high while a ballot is armed.
- busy, output, 1, high during HOLD; the vote-accepted LED drive.
- blocked_press, output, 1, one-cycle pulse when a press is rejected.
- blocked_count, output, 8, saturating count of rejected presses.
- total_votes, output, 16, saturating count of accepted votes.
- timeout, output, 1, one-cycle pulse when an armed ballot expires.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs and internal counters go to 0.
  - Reset asserted mid-HOLD or mid-ARMED discards the ballot. A vote_strobe already issued is not retracted.
- States: IDLE, ARMED, HOLD. Encoding is free. All outputs are registered.
- IDLE:
  - If ballot_issue=1 and mode=0 at an edge, go to ARMED; ready=1 from the next cycle.
  - If ballot_issue=1 and mode=1, ignore it.
  - If cand_valid!=0 while mode=0, pulse blocked_press for one cycle and increment blocked_count (saturate at 255).
  - If cand_valid!=0 while mode=1, take no action (result-display browsing).
- ARMED:
  - mode=1 at an edge: go to IDLE, ready drops, no vote.
  - cand_valid!=0 and mode=0 at edge N:
    - Select the lowest-index set bit.
    - vote_strobe = one-hot(select) for exactly cycle N+1, then 0.
    - total_votes increments at edge N (saturate at 0xFFFF).
    - Go to HOLD; ready=0 and busy=1 from cycle N+1.
    - Simultaneous presses: only the lowest index is accepted; the other bits are neither counted nor reported as blocked.
  - ballot_issue while ARMED is ignored; a ballot never stacks.
- HOLD:
  - busy=1 for exactly HOLD_CYCLES cycles, then go to IDLE with busy=0.
  - cand_valid during HOLD counts as blocked (pulse plus count, mode=0 only).
  - ballot_issue during HOLD is ignored; the officer must re-issue after busy falls.
  - A mode change during HOLD does not shorten HOLD.
- Same-edge events:
  - cand_valid on the edge that moves IDLE to ARMED is treated as blocked; the ballot remains armed.
  - cand_valid on the last HOLD edge is blocked; state goes to IDLE.
- vote_strobe is never multi-hot and is never asserted while mode=1 at the sampling edge.
- Every vote_strobe is followed by at least HOLD_CYCLES+1 cycles before the next vote_strobe can occur.

Optional Feature:
- Macro: BALLOT_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ARMED and increments each ARMED cycle.
  - If TIMEOUT_CYCLES cycles elapse with no accepted press, go to IDLE and pulse timeout for one cycle; ready drops in the same cycle.
  - A press on the expiry edge wins: the vote is accepted and there is no timeout pulse.
- Without the macro: ARMED persists indefinitely, timeout is tied to 0, and no timeout counter is synthesized.

Test Plan:
- Reset, then ballot_issue pulse, then cand_valid=4'b0100 two cycles later -> vote_strobe=4'b0100 for one cycle; total_votes=1; busy high for 10 cycles; ready returns to 0.
- Armed ballot, cand_valid=4'b1010 in a single cycle -> vote_strobe=4'b0010 only; blocked_count unchanged; total_votes=1.
- No ballot, three cand_valid pulses, then a fourth pulse during HOLD of a legitimate vote -> blocked_count=4; four blocked_press pulses; no extra vote_strobe.
- Armed ballot, then mode=1 before any press -> ready=0 next cycle; later cand_valid pulses give no vote_strobe and no blocked count.
- reset driven low mid-HOLD (cycle 5 of 10) -> busy, ready, total_votes and blocked_count all 0 immediately without waiting for a clock edge; state is IDLE.
- BALLOT_TIMEOUT_EN with TIMEOUT_CYCLES=20, ballot armed with no press -> timeout pulse at cycle 20; ready=0; a subsequent press is blocked.
